wt_mem_arbiter: RTL and testbench



---
 rtl/wt_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_wt_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_arbiter.sv
// wt_mem_arbiter: shares one memory request/return channel between the I$ and D$.
//
// Requests from the two caches are arbitrated (round-robin or fixed I$ priority).
// The winner is acked combinationally and held in a one-entry issue buffer until
// the adapter accepts it. The source of every granted transaction is pushed into
// an in-order FIFO so each return can be steered back to its cache. Invalidations
// bypass the FIFO and always go to the D$.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ic_req_i/ic_ack_o/ic_data_i   I$ request channel (req held until ack)
//   dc_req_i/dc_ack_o/dc_data_i   D$ request channel (req held until ack)
//   mem_req_vld_o/mem_req_rdy_i   buffered request to the adapter
//   mem_req_o/mem_req_src_o       buffered payload and source (0 = I$, 1 = D$)
//   mem_rtrn_vld_i/_inv_i/mem_rtrn_i  return from the adapter (always accepted)
//   ic_rtrn_vld_o/ic_rtrn_o       registered return to the I$
//   dc_rtrn_vld_o/dc_rtrn_o       registered return to the D$
//   outstanding_o                 granted-but-unreturned transaction count
//   err_o                         sticky: untracked non-invalidation return seen
module wt_mem_arbiter #(
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned RtrnWidth      = 160,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IcachePrio     = 0,
  localparam int unsigned PtrW          = $clog2(MaxOutstanding),
  localparam int unsigned CntW          = PtrW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ic_req_i,
  output logic                 ic_ack_o,
  input  logic [ReqWidth-1:0]  ic_data_i,
  input  logic                 dc_req_i,
  output logic                 dc_ack_o,
  input  logic [ReqWidth-1:0]  dc_data_i,
  output logic                 mem_req_vld_o,
  input  logic                 mem_req_rdy_i,
  output logic [ReqWidth-1:0]  mem_req_o,
  output logic                 mem_req_src_o,
  input  logic                 mem_rtrn_vld_i,
  input  logic                 mem_rtrn_inv_i,
  input  logic [RtrnWidth-1:0] mem_rtrn_i,
  output logic                 ic_rtrn_vld_o,
  output logic [RtrnWidth-1:0] ic_rtrn_o,
  output logic                 dc_rtrn_vld_o,
  output logic [RtrnWidth-1:0] dc_rtrn_o,
  output logic [CntW-1:0]      outstanding_o,
  output logic                 err_o
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e               state_q, state_d;
  logic [ReqWidth-1:0]  buf_data_q;
  logic                 buf_src_q;
  logic                 rr_last_dc_q;   // 1: D$ was granted last, so I$ wins next conflict
  logic                 fifo_q [MaxOutstanding];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      issued;
  logic                 ic_rtrn_vld_q, dc_rtrn_vld_q;
  logic [RtrnWidth-1:0] rtrn_data_q;
  logic                 err_q;

  logic grant, win_src, rtrn_trk, pop, bad_rtrn, head_src;

  always_comb begin
    state_d  = state_q;
    win_src  = 1'b0;
    grant    = 1'b0;
    ic_ack_o = 1'b0;
    dc_ack_o = 1'b0;

    if (ic_req_i && dc_req_i) begin
      win_src = (IcachePrio != 0) ? 1'b0 : ~rr_last_dc_q;
    end else begin
      win_src = dc_req_i;
    end

    // Grant decision uses the registered count; a same-cycle return does not free a slot.
    grant    = (state_q == StIdle) && (cnt_q < CntW'(MaxOutstanding)) && (ic_req_i || dc_req_i);
    ic_ack_o = grant && !win_src;
    dc_ack_o = grant && win_src;

    unique case (state_q)
      StIdle:  if (grant) state_d = StHold;
      StHold:  if (mem_req_rdy_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // The buffered entry is in the FIFO but not yet issued, so it cannot be returned.
    issued   = cnt_q - CntW'(state_q == StHold);
    rtrn_trk = mem_rtrn_vld_i && !mem_rtrn_inv_i;
    pop      = rtrn_trk && (issued != '0);
    bad_rtrn = rtrn_trk && (issued == '0);
    head_src = fifo_q[rd_ptr_q];

    cnt_d = cnt_q;
    if (grant && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !grant) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      buf_data_q    <= '0;
      buf_src_q     <= 1'b0;
      rr_last_dc_q  <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      ic_rtrn_vld_q <= 1'b0;
      dc_rtrn_vld_q <= 1'b0;
      rtrn_data_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        buf_data_q   <= win_src ? dc_data_i : ic_data_i;
        buf_src_q    <= win_src;
        rr_last_dc_q <= win_src;
        wr_ptr_q     <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      ic_rtrn_vld_q <= pop && !head_src;
      dc_rtrn_vld_q <= (mem_rtrn_vld_i && mem_rtrn_inv_i) || (pop && head_src);
      if ((mem_rtrn_vld_i && mem_rtrn_inv_i) || pop) begin
        rtrn_data_q <= mem_rtrn_i;
      end
      if (bad_rtrn) begin
        err_q <= 1'b1;
      end
    end
  end

  // Source storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      fifo_q[wr_ptr_q] <= win_src;
    end
  end

  assign mem_req_vld_o = (state_q == StHold);
  assign mem_req_o     = buf_data_q;
  assign mem_req_src_o = buf_src_q;
  assign ic_rtrn_vld_o = ic_rtrn_vld_q;
  assign dc_rtrn_vld_o = dc_rtrn_vld_q;
  assign ic_rtrn_o     = rtrn_data_q;
  assign dc_rtrn_o     = rtrn_data_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
module tb_wt_mem_arbiter;

  localparam int unsigned ReqWidth  = 128;
  localparam int unsigned RtrnWidth = 160;

  logic clk_i = 1'b0;
  logic rst_i;
  logic ic_req_i, dc_req_i, mem_req_rdy_i, mem_rtrn_vld_i, mem_rtrn_inv_i;
  logic [ReqWidth-1:0]  ic_data_i, dc_data_i;
  logic [RtrnWidth-1:0] mem_rtrn_i;

  // Round-robin instance outputs
  logic ic_ack_o, dc_ack_o, mem_req_vld_o, mem_req_src_o, ic_rtrn_vld_o, dc_rtrn_vld_o, err_o;
  logic [ReqWidth-1:0]  mem_req_o;
  logic [RtrnWidth-1:0] ic_rtrn_o, dc_rtrn_o;
  logic [2:0]           outstanding_o;

  // Fixed I$-priority instance outputs
  logic p_ic_ack, p_dc_ack, p_vld, p_src, p_ic_rvld, p_dc_rvld, p_err;
  logic [ReqWidth-1:0]  p_req;
  logic [RtrnWidth-1:0] p_ic_rtrn, p_dc_rtrn;
  logic [2:0]           p_out;

  always #5 clk_i = ~clk_i;

  wt_mem_arbiter #(.ReqWidth(ReqWidth), .RtrnWidth(RtrnWidth), .MaxOutstanding(4),
                   .IcachePrio(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_i(ic_req_i), .ic_ack_o(ic_ack_o), .ic_data_i(ic_data_i),
    .dc_req_i(dc_req_i), .dc_ack_o(dc_ack_o), .dc_data_i(dc_data_i),
    .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_o(mem_req_o), .mem_req_src_o(mem_req_src_o),
    .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_inv_i(mem_rtrn_inv_i), .mem_rtrn_i(mem_rtrn_i),
    .ic_rtrn_vld_o(ic_rtrn_vld_o), .ic_rtrn_o(ic_rtrn_o),
    .dc_rtrn_vld_o(dc_rtrn_vld_o), .dc_rtrn_o(dc_rtrn_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  wt_mem_arbiter #(.ReqWidth(ReqWidth), .RtrnWidth(RtrnWidth), .MaxOutstanding(4),
                   .IcachePrio(1)) dut_p (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_i(ic_req_i), .ic_ack_o(p_ic_ack), .ic_data_i(ic_data_i),
    .dc_req_i(dc_req_i), .dc_ack_o(p_dc_ack), .dc_data_i(dc_data_i),
    .mem_req_vld_o(p_vld), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_o(p_req), .mem_req_src_o(p_src),
    .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_inv_i(mem_rtrn_inv_i), .mem_rtrn_i(mem_rtrn_i),
    .ic_rtrn_vld_o(p_ic_rvld), .ic_rtrn_o(p_ic_rtrn),
    .dc_rtrn_vld_o(p_dc_rvld), .dc_rtrn_o(p_dc_rtrn),
    .outstanding_o(p_out), .err_o(p_err)
  );

  typedef struct {
    logic       ic, dc, rdy, rv, inv;
    logic [7:0] rd;
    logic       e_ica, e_dca, e_vld, e_src, e_icr, e_dcr;
    logic [7:0] e_rd;
    logic [2:0] e_out;
    logic       e_err;
    logic       chk_p, e_pica, e_pdca;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input int ic, dc, rdy, rv, inv, rd, ica, dca, vld, src, icr, dcr,
                              erd, out, err, cp = 0, pica = 0, pdca = 0);
    vec_t r;
    r.ic = ic[0]; r.dc = dc[0]; r.rdy = rdy[0]; r.rv = rv[0]; r.inv = inv[0]; r.rd = rd[7:0];
    r.e_ica = ica[0]; r.e_dca = dca[0]; r.e_vld = vld[0]; r.e_src = src[0];
    r.e_icr = icr[0]; r.e_dcr = dcr[0]; r.e_rd = erd[7:0]; r.e_out = out[2:0]; r.e_err = err[0];
    r.chk_p = cp[0]; r.e_pica = pica[0]; r.e_pdca = pdca[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic ic, dc, rdy, rv, inv, input logic [7:0] rd);
    ic_req_i = ic; dc_req_i = dc; mem_req_rdy_i = rdy;
    mem_rtrn_vld_i = rv; mem_rtrn_inv_i = inv; mem_rtrn_i = {152'b0, rd};
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 8'h00);
    next();
    rst_i = 1'b0;
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v = vecs[i];
      drive(v.ic, v.dc, v.rdy, v.rv, v.inv, v.rd);
      @(negedge clk_i);
      chk($sformatf("%s[%0d] ic_ack", tag, i), 160'(ic_ack_o), 160'(v.e_ica));
      chk($sformatf("%s[%0d] dc_ack", tag, i), 160'(dc_ack_o), 160'(v.e_dca));
      chk($sformatf("%s[%0d] mem_vld", tag, i), 160'(mem_req_vld_o), 160'(v.e_vld));
      if (v.e_vld) begin
        chk($sformatf("%s[%0d] mem_src", tag, i), 160'(mem_req_src_o), 160'(v.e_src));
        chk($sformatf("%s[%0d] mem_req", tag, i), 160'(mem_req_o), v.e_src ? 160'h5A : 160'hA5);
      end
      chk($sformatf("%s[%0d] ic_rvld", tag, i), 160'(ic_rtrn_vld_o), 160'(v.e_icr));
      chk($sformatf("%s[%0d] dc_rvld", tag, i), 160'(dc_rtrn_vld_o), 160'(v.e_dcr));
      if (v.e_icr) chk($sformatf("%s[%0d] ic_rtrn", tag, i), ic_rtrn_o, 160'(v.e_rd));
      if (v.e_dcr) chk($sformatf("%s[%0d] dc_rtrn", tag, i), dc_rtrn_o, 160'(v.e_rd));
      chk($sformatf("%s[%0d] outstanding", tag, i), 160'(outstanding_o), 160'(v.e_out));
      chk($sformatf("%s[%0d] err", tag, i), 160'(err_o), 160'(v.e_err));
      if (v.chk_p) begin
        chk($sformatf("%s[%0d] prio ic_ack", tag, i), 160'(p_ic_ack), 160'(v.e_pica));
        chk($sformatf("%s[%0d] prio dc_ack", tag, i), 160'(p_dc_ack), 160'(v.e_pdca));
      end
      next();
    end
    vecs.delete();
  endtask

  initial begin
    ic_data_i = 128'hA5;
    dc_data_i = 128'h5A;
    do_reset();

    // Reset state
    @(negedge clk_i);
    chk("rst mem_req", 160'(mem_req_o), 160'h0);
    chk("rst ic_rtrn", ic_rtrn_o, 160'h0);
    chk("rst dc_rtrn", dc_rtrn_o, 160'h0);
    chk("rst mem_vld", 160'(mem_req_vld_o), 160'h0);
    chk("rst outstanding", 160'(outstanding_o), 160'h0);
    chk("rst err", 160'(err_o), 160'h0);
    next();

    // Single I$ request, then D$/I$ routing with an invalidation in between.
    //            ic dc rdy rv inv rd    ica dca vld src icr dcr erd  out err
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0,    0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h33, 0, 0, 0, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0, 'h33, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,    0, 1, 0, 0, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,    0, 0, 1, 1, 0, 0, 0,    1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0,    2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h11, 0, 0, 0, 0, 0, 0, 0,    2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 'h77, 0, 0, 0, 0, 0, 1, 'h11, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h22, 0, 0, 0, 0, 0, 1, 'h77, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0, 'h22, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0,    0, 0));
    run_vecs("route");

    // Conflict: RR alternates I$/D$, priority instance always picks I$; then credit limit.
    do_reset();
    //            ic dc rdy rv inv rd   ica dca vld src icr dcr erd out err  cp pica pdca
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,   0, 0,   1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0,   1, 0,   1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0,   1, 0,   1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0,   2, 0,   1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,   2, 0,   1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0,   3, 0,   1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0,   3, 0,   1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0,   4, 0,   1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,   4, 0,   1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0,   4, 0,   1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 1, 0, 1,   3, 0,   1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0,   4, 0,   1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,   4, 0,   1, 0, 0));
    run_vecs("conflict");

    // Error: untracked return right after reset.
    do_reset();
    drive(0, 0, 0, 1, 0, 8'h44);
    @(negedge clk_i);
    chk("err0 before", 160'(err_o), 160'h0);
    next();
    drive(0, 0, 0, 0, 0, 8'h00);
    @(negedge clk_i);
    chk("err0 set", 160'(err_o), 160'h1);
    chk("err0 ic_rvld", 160'(ic_rtrn_vld_o), 160'h0);
    chk("err0 dc_rvld", 160'(dc_rtrn_vld_o), 160'h0);
    next();
    @(negedge clk_i);
    chk("err0 sticky", 160'(err_o), 160'h1);
    next();

    // Error: the only grant is still buffered in HOLD.
    do_reset();
    drive(1, 0, 0, 0, 0, 8'h00);
    @(negedge clk_i);
    chk("err1 ic_ack", 160'(ic_ack_o), 160'h1);
    next();
    drive(0, 0, 0, 1, 0, 8'h55);
    @(negedge clk_i);
    chk("err1 hold vld", 160'(mem_req_vld_o), 160'h1);
    next();
    drive(0, 0, 0, 0, 0, 8'h00);
    @(negedge clk_i);
    chk("err1 set", 160'(err_o), 160'h1);
    chk("err1 ic_rvld", 160'(ic_rtrn_vld_o), 160'h0);
    chk("err1 dc_rvld", 160'(dc_rtrn_vld_o), 160'h0);
    chk("err1 outstanding", 160'(outstanding_o), 160'h1);
    next();

    // Mid-operation reset during HOLD with 3 outstanding and a return in flight.
    do_reset();
    drive(0, 0, 0, 1, 0, 8'h66);
    next();
    drive(1, 0, 0, 0, 0, 8'h00);
    @(negedge clk_i);
    chk("mrst err pre", 160'(err_o), 160'h1);
    chk("mrst ack0", 160'(ic_ack_o), 160'h1);
    next();
    drive(0, 0, 1, 0, 0, 8'h00);
    next();
    drive(0, 1, 0, 0, 0, 8'h00);
    @(negedge clk_i);
    chk("mrst ack1", 160'(dc_ack_o), 160'h1);
    next();
    drive(0, 0, 1, 0, 0, 8'h00);
    next();
    drive(1, 0, 0, 0, 0, 8'h00);
    @(negedge clk_i);
    chk("mrst ack2", 160'(ic_ack_o), 160'h1);
    next();
    drive(0, 0, 0, 1, 0, 8'h99);
    @(negedge clk_i);
    chk("mrst pre out", 160'(outstanding_o), 160'h3);
    chk("mrst pre vld", 160'(mem_req_vld_o), 160'h1);
    rst_i = 1'b1;
    next();
    rst_i = 1'b0;
    drive(1, 1, 0, 0, 0, 8'h00);
    @(negedge clk_i);
    chk("mrst vld", 160'(mem_req_vld_o), 160'h0);
    chk("mrst outstanding", 160'(outstanding_o), 160'h0);
    chk("mrst err", 160'(err_o), 160'h0);
    chk("mrst ic_rvld", 160'(ic_rtrn_vld_o), 160'h0);
    chk("mrst dc_rvld", 160'(dc_rtrn_vld_o), 160'h0);
    chk("mrst ic wins", 160'(ic_ack_o), 160'h1);
    chk("mrst dc loses", 160'(dc_ack_o), 160'h0);
    next();
    drive(0, 0, 0, 0, 0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
